// File: rtl/ahb_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_arbiter
// Brief    : Two-master AHB-Lite arbiter (core M1, debugger M2) with burst
//            lock, starvation guard and optional round-robin tie-breaking.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_arbiter #(
    parameter int MAX_WAIT    = 8,
    parameter int ROUND_ROBIN = 0
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic [1:0] HTRANS_M1,
    input  logic [1:0] HTRANS_M2,
    input  logic       HREADY,
    output logic       addr_sel,
    output logic       data_sel,
    output logic       HREADY_M1,
    output logic       HREADY_M2,
    output logic       grant_switch,
    output logic       starve
);

    localparam logic [1:0] C_IDLE     = 2'b00;
    localparam logic [1:0] C_BUSY     = 2'b01;
    localparam logic [1:0] C_SEQ      = 2'b11;
    localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

    logic       addr_sel_q, addr_sel_d;
    logic       data_sel_q;
    logic       grant_switch_q;
    logic       last_grant_q, last_grant_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic       w_req_m1, w_req_m2;
    logic       w_own_req, w_oth_req, w_locked;
    logic [1:0] w_own_trans;

    assign w_req_m1    = (HTRANS_M1 != C_IDLE);
    assign w_req_m2    = (HTRANS_M2 != C_IDLE);
    assign w_own_trans = addr_sel_q ? HTRANS_M2 : HTRANS_M1;
    assign w_own_req   = addr_sel_q ? w_req_m2 : w_req_m1;
    assign w_oth_req   = addr_sel_q ? w_req_m1 : w_req_m2;
    // An owner mid-burst keeps the bus even against a starving peer.
    assign w_locked    = (w_own_trans == C_SEQ) || (w_own_trans == C_BUSY);

    always_comb begin
        addr_sel_d   = addr_sel_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        if (HREADY) begin
            if (!w_locked && w_oth_req) begin
                if (!w_own_req) begin
                    addr_sel_d = ~addr_sel_q;
                end else if (wait_cnt_q == C_MAX_WAIT) begin
                    addr_sel_d = ~addr_sel_q;
                end else if (ROUND_ROBIN != 0) begin
                    addr_sel_d = ~last_grant_q;
                end else begin
                    addr_sel_d = 1'b1;
                end
            end
            if (addr_sel_d != addr_sel_q) begin
                wait_cnt_d   = 8'd0;
                last_grant_d = addr_sel_d;
            end else if (!w_oth_req) begin
                wait_cnt_d = 8'd0;
            end else if (wait_cnt_q != C_MAX_WAIT) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            addr_sel_q     <= 1'b0;
            data_sel_q     <= 1'b0;
            grant_switch_q <= 1'b0;
            last_grant_q   <= 1'b0;
            wait_cnt_q     <= 8'd0;
        end else begin
            addr_sel_q     <= addr_sel_d;
            last_grant_q   <= last_grant_d;
            wait_cnt_q     <= wait_cnt_d;
            grant_switch_q <= (addr_sel_d != addr_sel_q);
            if (HREADY) begin
                data_sel_q <= addr_sel_q;
            end
        end
    end

    assign addr_sel     = addr_sel_q;
    assign data_sel     = data_sel_q;
    assign grant_switch = grant_switch_q;
    assign starve       = (wait_cnt_q == C_MAX_WAIT);
    // A requesting master that owns neither phase is held off the bus.
    assign HREADY_M1    = HREADY & ~(w_req_m1 &  addr_sel_q &  data_sel_q);
    assign HREADY_M2    = HREADY & ~(w_req_m2 & ~addr_sel_q & ~data_sel_q);

endmodule
`default_nettype wire

// File: doc/ahb_lite_arbiter.md
AHB_LITE_ARBITER -- requirements
Module: ahb_lite_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8: lost arbitration opportunities before the waiting master is force-granted; legal range 1..255.
REQ-002 Parameter ROUND_ROBIN, default 0: 0 = fixed priority with M2 (debugger) winning ties; 1 = alternate on ties.
REQ-003 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-004 Port Rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port HTRANS_M1, input, 2: transfer type from master 1 (core).
REQ-006 Port HTRANS_M2, input, 2: transfer type from master 2 (debugger).
REQ-007 Port HREADY, input, 1: shared bus ready from the slave side.
REQ-008 Port addr_sel, output, 1: address-phase owner; 0 = M1, 1 = M2; drives the address mux.
REQ-009 Port data_sel, output, 1: data-phase owner; 0 = M1, 1 = M2; drives the HWDATA/HRESP mux.
REQ-010 Port HREADY_M1, output, 1: gated ready returned to M1.
REQ-011 Port HREADY_M2, output, 1: gated ready returned to M2.
REQ-012 Port grant_switch, output, 1: one-cycle pulse in the cycle after addr_sel changes.
REQ-013 Port starve, output, 1: high while the wait counter equals MAX_WAIT.

Function
REQ-014 A master requests (req_x) when its HTRANS is not IDLE (2'b00).
REQ-015 Arbitration happens only at rising edges where HREADY=1; addr_sel, data_sel and the wait counter SHALL NOT change when HREADY=0.
REQ-016 Burst lock: no re-arbitration while the current owner's HTRANS is SEQ (2'b11) or BUSY (2'b01); addr_sel holds.
REQ-017 When arbitration is open, next owner selection:
- neither master requests: park, addr_sel unchanged;
- exactly one master requests: that master;
- both request and the wait counter equals MAX_WAIT: the non-owner;
- both request, ROUND_ROBIN=0: M2;
- both request, ROUND_ROBIN=1: the master not granted at the previous switch (last_grant register).
REQ-018 data_sel SHALL load addr_sel at every rising edge where HREADY=1, giving exactly one cycle of address-to-data pipeline.
REQ-019 Non-owner stall: HREADY_Mx = HREADY AND NOT (req_x AND addr_sel!=x AND data_sel!=x); the stalled master holds its address stable per AHB-Lite.
REQ-020 HREADY_Mx is a direct pass-through of HREADY whenever master x owns the address phase or the data phase.
REQ-021 Wait counter (8-bit) behaviour:
- increments at HREADY=1 edges where the non-owner requests and is not granted;
- saturates at MAX_WAIT;
- clears to 0 on any change of addr_sel.
REQ-022 The wait counter clears to 0 when the non-owner drops its request.
REQ-023 Forced grant at MAX_WAIT overrides priority but SHALL NOT override the burst lock of REQ-016.
REQ-024 grant_switch is registered and goes high for exactly one cycle following each edge at which addr_sel changed.
REQ-025 Simultaneous events: a switch and a data-phase handoff at the same edge are legal; data_sel takes the old addr_sel, and addr_sel takes the new owner.
REQ-026 All outputs SHALL be glitch-free with respect to the registered state; HREADY_Mx is the only combinational path, from HREADY and HTRANS_Mx.

Reset
REQ-027 While Rst=1, regardless of clk: addr_sel=0, data_sel=0, grant_switch=0, starve=0, wait counter=0, last_grant=0.
REQ-028 While Rst=1, HREADY_M1 and HREADY_M2 follow REQ-019 using the reset state values.
REQ-029 Assertion of Rst mid-transfer SHALL abandon any pending grant immediately; after release, ownership resumes with M1.
REQ-030 The first arbitration after release occurs at the first rising edge with Rst=0 and HREADY=1.

Verification
REQ-031 Reset then HTRANS_M2=NONSEQ, HTRANS_M1=IDLE, HREADY=1 -> HREADY_M2=0 for one cycle; addr_sel=1 after edge 1; data_sel=1 after edge 2; grant_switch pulses once.
REQ-032 ROUND_ROBIN=0, both masters NONSEQ continuously, HREADY=1, MAX_WAIT=8 -> M2 owns; starve=1 after 8 edges; addr_sel=0 at edge 9; counter=0.
REQ-033 M1 owner in a 4-beat INCR4 burst (NONSEQ,SEQ,SEQ,SEQ) with M2 requesting -> addr_sel stays 0 through all SEQ beats; switches to 1 only after the last beat.
REQ-034 M2 requesting, HREADY held 0 for 5 cycles -> addr_sel, data_sel and counter unchanged; HREADY_M2=0 throughout.
REQ-035 ROUND_ROBIN=1, both requesting NONSEQ every cycle -> addr_sel alternates 1,0,1,0 on consecutive HREADY=1 edges.
REQ-036 Rst asserted asynchronously mid-cycle while addr_sel=1 and the counter is 5 -> addr_sel=0, data_sel=0, counter=0 before the next clk edge.
